// File: rtl/dma_engine.sv
// Single-channel word-copy DMA master: software-programmed SRC/DST/LEN,
// read-capture-write per word, bounded bursts per grant, done/error interrupt.
module dma_engine #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_select,
  input  logic [3:0]  cfg_address,
  input  logic [31:0] cfg_write_data,
  input  logic [1:0]  cfg_mode,
  output logic [31:0] cfg_read_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  input  logic        ds_cpu_halt,
  output logic [31:0] dma_address,
  output logic [31:0] dma_write_data,
  output logic [1:0]  dma_reqw,
  output logic        dma_reqs,
  output logic [1:0]  dma_mode,
  input  logic [31:0] dma_read_data,
  output logic        irq
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE,
    S_REL
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_src;
  logic [31:0]   r_dst;
  logic [31:0]   r_buf;
  logic [15:0]   r_len;
  logic [BW-1:0] r_burst;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_ie;
  logic          r_irq;

  logic          w_cfg_wr;
  logic [1:0]    w_offset;
  logic          w_start;
  logic          w_misalign;
  logic          w_own;
  logic          w_capture;
  logic          w_word_done;
  logic          w_last_of_burst;
  logic          w_unused;

  assign w_offset        = cfg_address[3:2];
  assign w_cfg_wr        = cfg_select && (cfg_mode == 2'b10);
  assign w_start         = w_cfg_wr && (w_offset == 2'd3) && cfg_write_data[0] && !r_busy;
  assign w_misalign      = (r_src[1:0] != 2'b00) || (r_dst[1:0] != 2'b00);
  assign w_own           = bus_gnt && !ds_cpu_halt;
  assign w_last_of_burst = (r_burst == BW'(MAX_BURST - 1));
  assign w_unused        = ^cfg_address[1:0];

  assign dma_reqw = 2'b10;
  assign dma_reqs = 1'b0;
  assign irq      = r_irq;

  always_comb begin
    cfg_read_data = 32'd0;
    case (w_offset)
      2'd0: cfg_read_data = r_src;
      2'd1: cfg_read_data = r_dst;
      2'd2: cfg_read_data = {16'd0, r_len};
      2'd3: cfg_read_data = {27'd0, r_err, r_ie, r_done, r_busy, 1'b0};
      default: cfg_read_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Any loss of ownership mid-word drops back to REQ with the bus idle that
  // cycle; the whole read-capture-write is replayed once ownership returns.
  always_comb begin
    w_state_next   = r_state;
    bus_req        = 1'b0;
    dma_mode       = 2'b00;
    dma_address    = 32'd0;
    dma_write_data = 32'd0;
    w_capture      = 1'b0;
    w_word_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_misalign && (r_len != 16'd0)) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (w_own) begin
          w_state_next = S_RD;
        end
      end
      S_RD: begin
        bus_req = 1'b1;
        if (w_own) begin
          dma_mode     = 2'b01;
          dma_address  = r_src;
          w_state_next = S_CAP;
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_CAP: begin
        bus_req = 1'b1;
        if (w_own) begin
          w_capture    = 1'b1;
          w_state_next = S_WR;
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_WR: begin
        bus_req = 1'b1;
        if (w_own) begin
          dma_mode       = 2'b10;
          dma_address    = r_dst;
          dma_write_data = r_buf;
          w_word_done    = 1'b1;
          if (r_len == 16'd1) begin
            w_state_next = S_DONE;
          end else if (w_last_of_burst) begin
            w_state_next = S_REL;
          end else begin
            w_state_next = S_RD;
          end
        end else begin
          w_state_next = S_REQ;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      S_REL:   w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status-set assignments sit after the write-1-to-clear ones so a
  // same-cycle set always wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src   <= 32'd0;
      r_dst   <= 32'd0;
      r_len   <= 16'd0;
      r_buf   <= 32'd0;
      r_burst <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ie    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= r_done & r_ie;

      if (w_cfg_wr && !r_busy) begin
        case (w_offset)
          2'd0:    r_src <= cfg_write_data;
          2'd1:    r_dst <= cfg_write_data;
          2'd2:    r_len <= cfg_write_data[15:0];
          default: ;
        endcase
      end

      if (w_cfg_wr && (w_offset == 2'd3)) begin
        r_ie <= cfg_write_data[3];
        if (cfg_write_data[2]) r_done <= 1'b0;
        if (cfg_write_data[4]) r_err  <= 1'b0;
      end

      if (w_start) begin
        if (w_misalign) begin
          r_err  <= 1'b1;
          r_done <= 1'b1;
        end else if (r_len == 16'd0) begin
          r_done <= 1'b1;
        end else begin
          r_busy  <= 1'b1;
          r_burst <= '0;
        end
      end

      if (w_capture) begin
        r_buf <= dma_read_data;
      end

      if (w_word_done) begin
        r_src   <= r_src + 32'd4;
        r_dst   <= r_dst + 32'd4;
        r_len   <= r_len - 16'd1;
        r_burst <= r_burst + 1'b1;
      end

      if (r_state == S_REL) begin
        r_burst <= '0;
      end

      if (r_state == S_DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: register table, directed transfers with burst/halt/error
// corners, and randomized transfers checked against an arithmetic copy model.
module tb_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_select;
  logic [3:0]  cfg_address;
  logic [31:0] cfg_write_data;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_read_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        ds_cpu_halt;
  logic [31:0] dma_address;
  logic [31:0] dma_write_data;
  logic [1:0]  dma_reqw;
  logic        dma_reqs;
  logic [1:0]  dma_mode;
  logic [31:0] dma_read_data;
  logic        irq;

  logic        gnt_en;

  always #5 clk = ~clk;

  dma_engine #(.MAX_BURST(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_select     (cfg_select),
    .cfg_address    (cfg_address),
    .cfg_write_data (cfg_write_data),
    .cfg_mode       (cfg_mode),
    .cfg_read_data  (cfg_read_data),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .ds_cpu_halt    (ds_cpu_halt),
    .dma_address    (dma_address),
    .dma_write_data (dma_write_data),
    .dma_reqw       (dma_reqw),
    .dma_reqs       (dma_reqs),
    .dma_mode       (dma_mode),
    .dma_read_data  (dma_read_data),
    .irq            (irq)
  );

  // Arbiter model: grants whenever requested unless the bench withholds it.
  assign bus_gnt = bus_req & gnt_en;

  // Slave memory: unwritten words return a seeded address hash; reads are registered.
  logic [31:0] mem [0:4095];
  bit          wv  [0:4095];
  logic [31:0] seed;
  logic [31:0] rd_q;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (dma_mode == 2'b10) begin
      mem[dma_address[13:2]] <= dma_write_data;
      wv[dma_address[13:2]]  <= 1'b1;
    end
    if (dma_mode == 2'b01) begin
      rd_q <= wv[dma_address[13:2]] ? mem[dma_address[13:2]] : pat(dma_address);
    end
  end
  assign dma_read_data = rd_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic sel = 1'b1);
    cfg_select     = sel;
    cfg_mode       = 2'b10;
    cfg_address    = a;
    cfg_write_data = d;
    @(posedge clk); #1;
    cfg_select = 1'b0;
    cfg_mode   = 2'b00;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    cfg_address = a;
    cfg_select  = 1'b1;
    cfg_mode    = 2'b01;
    #1;
    d = cfg_read_data;
    cfg_select = 1'b0;
    cfg_mode   = 2'b00;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    cfg_read(a, v);
    check(name, v, exp);
  endtask

  // Per-transfer observations
  int st_rd, st_wr, st_first, st_last;
  int st_drops[$];
  bit st_to;

  task automatic wait_xfer(input int len, input bit rnd, input int halt_word, input int limit);
    int halt_cnt;
    bit trig;
    halt_cnt = 0;
    trig     = 1'b0;
    st_rd    = 0;
    st_wr    = 0;
    st_first = -1;
    st_last  = -1;
    st_drops.delete();
    st_to    = 1'b1;
    cfg_address = 4'hC;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (dma_mode == 2'b01) begin
        st_rd++;
        if (st_first < 0) st_first = c;
        if (halt_word > 0 && !trig && st_wr == halt_word - 1) begin
          trig     = 1'b1;
          halt_cnt = 3;
        end
      end
      if (dma_mode == 2'b10) begin
        st_wr++;
        st_last = c;
      end
      if (!bus_req && st_wr > 0 && st_wr < len) st_drops.push_back(st_wr);
      if (cfg_read_data[2]) begin
        st_to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (rnd) begin
        gnt_en      = ($urandom_range(0, 3) != 0);
        ds_cpu_halt = ($urandom_range(0, 7) == 0);
      end else begin
        ds_cpu_halt = (halt_cnt > 0);
        if (halt_cnt > 0) halt_cnt--;
      end
    end
    @(posedge clk); #1;
    gnt_en      = 1'b1;
    ds_cpu_halt = 1'b0;
    check("xfer_timeout", 32'(st_to), 32'd0);
  endtask

  task automatic check_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    logic [31:0] a;
    for (int i = 0; i < len; i++) begin
      a = dst + 32'(4 * i);
      check("dst_word", wv[a[13:2]] ? mem[a[13:2]] : 32'hxxxxxxxx, pat(src + 32'(4 * i)));
    end
  endtask

  task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                          input logic ie, input bit rnd, input int halt_word);
    seed = $urandom;
    cfg_write(4'h0, src);
    cfg_write(4'h4, dst);
    cfg_write(4'h8, 32'(len));
    cfg_write(4'hC, {28'd0, ie, 3'b001});
    wait_xfer(len, rnd, halt_word, 3000);
    $display("xfer src=%h dst=%h len=%0d rnd=%0d halt=%0d reads=%0d writes=%0d",
             src, dst, len, rnd, halt_word, st_rd, st_wr);
    check("words_written", 32'(st_wr), 32'(len));
    if (rnd) begin
      check("reads_at_least_len", 32'(st_rd >= len), 32'd1);
    end else begin
      check("reads", 32'(st_rd), 32'(len + ((halt_word > 0) ? 1 : 0)));
      check("req_drops", 32'(st_drops.size()), 32'((len - 1) / 8));
    end
    if (!rnd && halt_word == 0) begin
      check("bus_cycles", 32'(st_last - st_first + 1), 32'(3 * len + 2 * ((len - 1) / 8)));
    end
    check_copy(src, dst, len);
    check_reg("src_final", 4'h0, src + 32'(4 * len));
    check_reg("dst_final", 4'h4, dst + 32'(4 * len));
    check_reg("len_final", 4'h8, 32'd0);
    check_reg("ctrl_final", 4'hC, {28'd0, ie, 3'b100});
    check("irq_done", 32'(irq), 32'(ie));
    cfg_write(4'hC, {28'd0, ie, 3'b100});
    @(posedge clk); #1;
    check("irq_cleared", 32'(irq), 32'd0);
    check_reg("ctrl_cleared", 4'hC, {28'd0, ie, 3'b000});
  endtask

  typedef struct {
    logic        sel;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] v;
    int          cnt;
    bit          found;
    bit          req_seen;

    vecs[0] = '{1'b1, 1'b1, 4'h0, 32'hDEADBEEC, 32'hDEADBEEC};
    vecs[1] = '{1'b1, 1'b1, 4'h4, 32'h12345678, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 4'h8, 32'hABCD0007, 32'h00000007};
    vecs[3] = '{1'b1, 1'b0, 4'h1, 32'h00000000, 32'hDEADBEEC};
    vecs[4] = '{1'b1, 1'b0, 4'hB, 32'h00000000, 32'h00000007};
    vecs[5] = '{1'b0, 1'b1, 4'h0, 32'hFFFFFFF0, 32'hDEADBEEC};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 32'h00000008, 32'h00000008};
    vecs[7] = '{1'b1, 1'b1, 4'hC, 32'h00000012, 32'h00000000};
    vecs[8] = '{1'b1, 1'b1, 4'h5, 32'hCAFEF00C, 32'hCAFEF00C};
    vecs[9] = '{1'b1, 1'b1, 4'hC, 32'h00000008, 32'h00000008};

    reset          = 1'b1;
    cfg_select     = 1'b0;
    cfg_address    = 4'h0;
    cfg_write_data = 32'd0;
    cfg_mode       = 2'b00;
    ds_cpu_halt    = 1'b0;
    gnt_en         = 1'b1;
    seed           = 32'h1234_5678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_dma_mode", 32'(dma_mode), 32'd0);
    check("rst_dma_address", dma_address, 32'd0);
    check("rst_dma_wdata", dma_write_data, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_reqw", 32'(dma_reqw), 32'd2);
    check("rst_reqs", 32'(dma_reqs), 32'd0);
    check_reg("rst_src", 4'h0, 32'd0);
    check_reg("rst_dst", 4'h4, 32'd0);
    check_reg("rst_len", 4'h8, 32'd0);
    check_reg("rst_ctrl", 4'hC, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) cfg_write(vecs[i].addr, vecs[i].data, vecs[i].sel);
      cfg_read(vecs[i].addr, v);
      $display("vec %0d addr=%h read=%h", i, vecs[i].addr, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // Three-word copy with interrupt enabled
    run_xfer(32'h3000, 32'h3100, 3, 1'b1, 1'b0, 0);
    // Twenty words: request drops after words 8 and 16
    run_xfer(32'h1100, 32'h2100, 20, 1'b0, 1'b0, 0);
    check("drop0", 32'((st_drops.size() > 0) ? st_drops[0] : -1), 32'd8);
    check("drop1", 32'((st_drops.size() > 1) ? st_drops[1] : -1), 32'd16);
    // Halt during capture of word 5
    run_xfer(32'h1200, 32'h2200, 20, 1'b0, 1'b0, 5);

    // Misaligned source: ERR and DONE, never a request
    cfg_write(4'h0, 32'h3002);
    cfg_write(4'h4, 32'h3100);
    cfg_write(4'h8, 32'd4);
    cfg_write(4'hC, 32'h1);
    check_reg("misalign_ctrl", 4'hC, 32'h14);
    req_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_req) req_seen = 1'b1;
    end
    @(posedge clk); #1;
    check("misalign_no_req", 32'(req_seen), 32'd0);
    cfg_write(4'hC, 32'h14);
    check_reg("misalign_cleared", 4'hC, 32'h0);
    $display("misaligned start checked");

    // Zero-length start, with a same-cycle DONE clear that the set must beat
    cfg_write(4'h0, 32'h3000);
    cfg_write(4'h8, 32'd0);
    cfg_write(4'hC, 32'h5);
    check_reg("len0_done", 4'hC, 32'h4);
    req_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_req || dma_mode != 2'b00) req_seen = 1'b1;
    end
    @(posedge clk); #1;
    check("len0_no_bus", 32'(req_seen), 32'd0);
    cfg_write(4'hC, 32'h4);
    check_reg("len0_cleared", 4'hC, 32'h0);
    $display("zero-length start checked");

    // Writes and START while busy are ignored
    seed   = $urandom;
    gnt_en = 1'b0;
    cfg_write(4'h0, 32'h1400);
    cfg_write(4'h4, 32'h2400);
    cfg_write(4'h8, 32'd2);
    cfg_write(4'hC, 32'h1);
    cfg_write(4'h8, 32'd7);
    cfg_write(4'h0, 32'h0);
    check_reg("busy_len", 4'h8, 32'd2);
    check_reg("busy_src", 4'h0, 32'h1400);
    check_reg("busy_ctrl", 4'hC, 32'h2);
    cfg_write(4'hC, 32'h1);
    check_reg("busy_ctrl2", 4'hC, 32'h2);
    gnt_en = 1'b1;
    wait_xfer(2, 1'b0, 0, 500);
    $display("xfer while-busy writes=%0d reads=%0d", st_wr, st_rd);
    check("busy_words", 32'(st_wr), 32'd2);
    check_copy(32'h1400, 32'h2400, 2);
    check_reg("busy_src_final", 4'h0, 32'h1408);
    cfg_write(4'hC, 32'h4);

    // Randomized grant/halt traffic
    for (int t = 0; t < 6; t++) begin
      run_xfer(32'h1000 + 32'(4 * $urandom_range(0, 990)),
               32'h2000 + 32'(4 * $urandom_range(0, 990)),
               int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)), 1'b1, 0);
    end

    // Reset during the write of word 2
    seed = $urandom;
    cfg_write(4'h0, 32'h1800);
    cfg_write(4'h4, 32'h2800);
    cfg_write(4'h8, 32'd4);
    cfg_write(4'hC, 32'h9);
    cnt   = 0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (dma_mode == 2'b10) begin
        cnt++;
        if (cnt == 2) begin
          found = 1'b1;
          break;
        end
      end
    end
    check("rst_mid_found", 32'(found), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_bus_req", 32'(bus_req), 32'd0);
    check("rstmid_mode", 32'(dma_mode), 32'd0);
    check("rstmid_address", dma_address, 32'd0);
    check("rstmid_wdata", dma_write_data, 32'd0);
    check("rstmid_irq", 32'(irq), 32'd0);
    check_reg("rstmid_ctrl", 4'hC, 32'd0);
    check_reg("rstmid_src", 4'h0, 32'd0);
    check_reg("rstmid_len", 4'h8, 32'd0);
    $display("reset mid-transfer checked");
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
